sr_latch_ctrl: RTL and testbench
================================

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 Parameter PULSE_CYC, default 4, number of clock cycles S or R is held high per command; legal range >=1.
REQ-002 Parameter SETTLE_CYC, default 8, maximum cycles allowed for latch feedback to confirm after the pulse; legal range >=1.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port cmd_valid  input  1  command request.
REQ-006 Port cmd_set  input  1  command value: 1 = set latch (q=1), 0 = reset latch (q=0).
REQ-007 Port cmd_ready  output  1  controller can accept a command.
REQ-008 Port s  output  1  registered set drive to the external NOR SR latch.
REQ-009 Port r  output  1  registered reset drive to the external NOR SR latch.
REQ-010 Port q_fb  input  1  latch q, asynchronous to clk.
REQ-011 Port qb_fb  input  1  latch qb, asynchronous to clk.
REQ-012 Port done  output  1  one-cycle pulse, command confirmed by feedback.
REQ-013 Port err  output  1  one-cycle pulse, confirmation timed out.
REQ-014 Port q_state  output  1  synchronized q_fb.

Function
REQ-015 Controller SHALL never drive s=1 and r=1 in the same cycle, under any stimulus including reset.
REQ-016 q_fb and qb_fb SHALL each pass through a two-flop synchronizer before any use; q_state is the synchronized q_fb.
REQ-017 FSM states SHALL be IDLE, PULSE, VERIFY.
REQ-018 IDLE: cmd_ready=1, s=r=0; on an edge sampling cmd_valid=1, capture cmd_set, load pulse counter, go PULSE.
REQ-019 PULSE: cmd_ready=0; s=captured value, r=inverse of captured value, held for exactly PULSE_CYC cycles after the accepting edge; then s=r=0, load settle counter, go VERIFY.
REQ-020 VERIFY: cmd_ready=0, s=r=0; at each edge, if synced q equals captured value and synced qb equals its inverse, assert done for the following cycle and go IDLE.
REQ-021 If SETTLE_CYC VERIFY edges pass without a match, err SHALL be asserted for one cycle and FSM SHALL go IDLE; done stays 0.
REQ-022 done and err SHALL never be asserted together; cmd_ready SHALL rise in the same cycle done or err is high.
REQ-023 A command matching the latch's current state SHALL still be pulsed and verified normally.
REQ-024 cmd_valid while cmd_ready=0 SHALL be ignored; no queuing.
REQ-025 Counters SHALL be sized $clog2(max(PULSE_CYC,SETTLE_CYC))+1 bits and SHALL not wrap.

Reset
REQ-026 rst_n low SHALL immediately, without a clock, force s=0, r=0, done=0, err=0, state IDLE, counters 0, synchronizer flops 0.
REQ-027 cmd_ready SHALL be 1 while in reset and after release; reset mid-PULSE or mid-VERIFY SHALL abort the command with neither done nor err.

Structure
REQ-028 Package sr_ctrl_pkg SHALL hold the FSM state enum and the default PULSE_CYC/SETTLE_CYC constants.
REQ-029 One sub-module sync2 (two-flop synchronizer, clk/rst_n, 1-bit) SHALL be instantiated twice, for q_fb and qb_fb.

Verification (PULSE_CYC=4, SETTLE_CYC=8, outputs driving the team's gate-level NOR SR latch)
REQ-030 rst_n=0 -> s=0, r=0, done=0, err=0, cmd_ready=1 with no clock edge.
REQ-031 Accept cmd_set=1 at edge E0 -> s=1 for exactly 4 cycles, r=0 throughout, q_fb=1, done high one cycle after edge E0+5, cmd_ready high in that same cycle.
REQ-032 Then accept cmd_set=0 -> r=1 for 4 cycles, s=0, q_fb=0/qb_fb=1, done one cycle.
REQ-033 Feedback forced q_fb=0, qb_fb=1, accept cmd_set=1 -> s pulses 4 cycles, err high one cycle after edge E0+12, done never asserted.
REQ-034 rst_n pulsed low during PULSE of a set command -> s falls asynchronously, latch retains its last state, no done/err, next command accepted normally.
REQ-035 cmd_valid held high continuously with alternating cmd_set over 20 commands -> each accepted only in IDLE, assertion s&&r never fires, one done per command.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sr_ctrl_pkg : shared state encoding and defaults for the SR latch controller
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sr_ctrl_pkg;

    localparam int DEF_PULSE_CYC  = 4;
    localparam int DEF_SETTLE_CYC = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

    // One spare bit above the largest load value so the down-counter never wraps.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ----------------------------------------------------------------------------
// sync2    : two-flop synchronizer for a single asynchronous input
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sr_latch_ctrl.sv
// ----------------------------------------------------------------------------
// sr_latch_ctrl : pulses S/R of an external NOR latch and confirms via feedback
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    input  logic qb_fb,
    output logic done,
    output logic err,
    output logic q_state
);

    localparam int              CNT_W       = cnt_width(PULSE_CYC, SETTLE_CYC);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic             cap;
    logic [CNT_W-1:0] cnt;
    logic             q_sync;
    logic             qb_sync;
    logic             match;

    sync2 u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_fb),
        .q     (q_sync)
    );

    sync2 u_sync_qb (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (qb_fb),
        .q     (qb_sync)
    );

    assign q_state = q_sync;

    // Both rails must agree; an illegal q=qb pair never counts as confirmed.
    assign match = (q_sync == cap) && (qb_sync == ~cap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cap       <= 1'b0;
            cnt       <= '0;
            s         <= 1'b0;
            r         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cap       <= cmd_set;
                        s         <= cmd_set;
                        r         <= ~cmd_set;
                        cnt       <= PULSE_LOAD;
                        cmd_ready <= 1'b0;
                        state     <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        s     <= 1'b0;
                        r     <= 1'b0;
                        cnt   <= SETTLE_LOAD;
                        state <= ST_VERIFY;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_VERIFY: begin
                    if (match) begin
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_IDLE;
                    end else if (cnt == '0) begin
                        err       <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    s         <= 1'b0;
                    r         <= 1'b0;
                    cnt       <= '0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sr_latch_ctrl : directed + random bench with a behavioural NOR latch
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sr_latch_ctrl;

    localparam int PULSE  = 4;
    localparam int SETTLE = 8;

    logic clk       = 1'b0;
    logic rst_n     = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_set   = 1'b0;
    logic cmd_ready, s, r, done, err, q_state;
    logic q_fb, qb_fb;

    logic latch_q  = 1'b0;
    logic force_en = 1'b0;
    logic force_q  = 1'b0;
    logic force_qb = 1'b0;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // NOR latch behaviour: S sets, R resets, neither holds.
    always @(s or r) begin
        if (s && !r)      latch_q = 1'b1;
        else if (r && !s) latch_q = 1'b0;
    end

    assign q_fb  = force_en ? force_q  : latch_q;
    assign qb_fb = force_en ? force_qb : ~latch_q;

    sr_latch_ctrl #(
        .PULSE_CYC  (PULSE),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_set   (cmd_set),
        .cmd_ready (cmd_ready),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .qb_fb     (qb_fb),
        .done      (done),
        .err       (err),
        .q_state   (q_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected timeline from the accepting edge E0: drive for PULSE edges,
    // first verify edge at E0+PULSE+1, timeout at E0+PULSE+SETTLE.
    task automatic run_cmd(input logic cmd, input bit hold, input int idx);
        bit exp_done;
        int last;
        exp_done = !force_en || (force_q == cmd && force_qb == !cmd);
        last     = exp_done ? PULSE + 1 : PULSE + SETTLE;
        chk($sformatf("c%0d_ready_pre", idx), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_set   = cmd;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            chk($sformatf("c%0d_k%0d_s", idx, k), s, (k < PULSE) ? cmd : 1'b0);
            chk($sformatf("c%0d_k%0d_r", idx, k), r, (k < PULSE) ? !cmd : 1'b0);
            chk($sformatf("c%0d_k%0d_done", idx, k), done, (k == last) && exp_done);
            chk($sformatf("c%0d_k%0d_err", idx, k), err, (k == last) && !exp_done);
            chk($sformatf("c%0d_k%0d_ready", idx, k), cmd_ready, k == last);
            if (done) done_cnt++;
            if (hold) begin
                if (k < last) cmd_set = 1'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        if (exp_done) chk($sformatf("c%0d_qstate", idx), q_state, cmd);
        if (!force_en) begin
            chk($sformatf("c%0d_qfb", idx), q_fb, cmd);
            chk($sformatf("c%0d_qbfb", idx), qb_fb, !cmd);
        end
    endtask

    initial begin
        int base;
        logic c;

        // Asynchronous reset before any clock edge.
        rst_n = 1'b0;
        #2;
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        chk("rst_ready_held", cmd_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(1'b1, 1'b0, 0);
        repeat (2) @(negedge clk);
        run_cmd(1'b0, 1'b0, 1);
        repeat (2) @(negedge clk);

        // Feedback stuck at q=0 while setting: must time out.
        force_en = 1'b1; force_q = 1'b0; force_qb = 1'b1;
        @(negedge clk);
        run_cmd(1'b1, 1'b0, 2);
        @(negedge clk);
        chk("to_err_clear", err, 0);
        chk("to_done_clear", done, 0);
        force_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a set pulse.
        run_cmd(1'b0, 1'b0, 3);
        cmd_valid = 1'b1; cmd_set = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ab_s0", s, 1);
        @(negedge clk);
        chk("ab_s1", s, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_s_async", s, 0);
        chk("ab_r_async", r, 0);
        chk("ab_ready_async", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < PULSE + SETTLE + 2; k++) begin
            @(negedge clk);
            chk($sformatf("ab_k%0d_done", k), done, 0);
            chk($sformatf("ab_k%0d_err", k), err, 0);
            chk($sformatf("ab_k%0d_s", k), s, 0);
        end
        chk("ab_latch_kept", latch_q, 1);
        run_cmd(1'b0, 1'b0, 4);
        repeat (2) @(negedge clk);

        // cmd_valid held high, alternating commands back to back.
        base = done_cnt;
        for (int i = 0; i < 20; i++) begin
            c = 1'(i);
            run_cmd(c, 1'b1, 10 + i);
        end
        cmd_valid = 1'b0;
        chk("cont_done_count", done_cnt - base, 20);
        repeat (2) @(negedge clk);

        // Random commands with random feedback faults.
        for (int i = 0; i < 12; i++) begin
            force_en = 1'($urandom_range(0, 1));
            force_q  = 1'($urandom);
            force_qb = 1'($urandom);
            repeat (2) @(negedge clk);
            run_cmd(1'($urandom), 1'b0, 40 + i);
            force_en = 1'b0;
            repeat (3) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
